// File: rtl/flappy_pkg.sv
// flappy_pkg: scene encodings, key codes, pipe field offsets and
// fixed-point physics constants shared by the game and view blocks.
package flappy_pkg;

    typedef enum logic [1:0] {
        SCENE_SPLASH   = 2'd0,
        SCENE_PLAYING  = 2'd1,
        SCENE_GAMEOVER = 2'd2
    } scene_e;

    localparam logic [7:0] KEY_SPACE = 8'd32;
    localparam logic [7:0] KEY_R     = 8'd114;

    localparam int POS_LSB = 16;
    localparam int MAX_LSB = 8;
    localparam int MIN_LSB = 0;

    // Units of 2^-FRAC_W per frame
    localparam int ACC1    = -4;
    localparam int ACC2    = -6;
    localparam int VEL_BND = 26;
    localparam int VEL0    = 70;
    localparam int ORIG    = 10;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic logic [7:0] pipe_max0(input int i);
        return 8'(30 - 5 * (i % 2) + ((i == 0) ? 5 : 0));
    endfunction

endpackage

// File: rtl/flappy_lfsr.sv
// flappy_lfsr: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1,
// free-running every cycle; source of recycled pipe gaps.
module flappy_lfsr
    import flappy_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= LFSR_SEED;
        else        r_lfsr <= {r_lfsr[6:0], w_fb};
    end

    assign lfsr = r_lfsr;

endmodule

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: scene FSM, fixed-point bird physics,
// scrolling/recycling pipes, collision and score.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int         N_PIPE       = 3,
    parameter int         FRAC_W       = 8,
    parameter int         PIPE_SPACING = 50,
    parameter int         SCROLL_DIV   = 3,
    parameter int         KP_BUFLEN    = 5,
    parameter int         GAP          = 10,
    parameter int         HIT_W        = 6,
    parameter logic [7:0] KEY_FLAP     = KEY_SPACE,
    parameter logic [7:0] KEY_RESTART  = KEY_R
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            inp,
    input  logic [7:0]            n_row,
    input  logic [7:0]            n_col,
    output logic [1:0]            scene,
    output logic [8:0]            bird,
    output logic [24*N_PIPE-1:0]  pipes,
    output logic [15:0]           score
);

    localparam int YW = 9 + FRAC_W;
    localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int NW = $clog2(N_PIPE + 1);
    localparam logic [CW-1:0] CNT_TC  = CW'(SCROLL_DIV - 1);
    localparam logic [7:0]    HIT_POS = 8'(HIT_W);
    localparam logic [7:0]    POS_REL = 8'(N_PIPE * PIPE_SPACING - 1);

    scene_e                r_scene, w_scene_nxt;
    logic signed [YW-1:0]  r_y, r_v, r_a;
    logic                  r_flapping;
    logic [KP_BUFLEN-1:0]  r_kpbuf;
    logic [CW-1:0]         r_cnt;
    logic [7:0]            r_pos [N_PIPE];
    logic [7:0]            r_max [N_PIPE];
    logic [7:0]            r_min [N_PIPE];
    logic [15:0]           r_score;

    logic [7:0]        w_lfsr, w_alt, w_rmin;
    logic              w_flap, w_tc, w_hit, w_dead, w_unused;
    logic [N_PIPE-1:0] w_rec;
    logic [NW-1:0]     w_nrec;
    logic [16:0]       w_sum;

    flappy_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (w_lfsr)
    );

    // Integer part has 8 magnitude bits, so only the negative clamp applies
    assign w_alt    = r_y[YW-1] ? 8'd0 : r_y[FRAC_W+7:FRAC_W];
    assign w_flap   = |r_kpbuf;
    assign w_tc     = (r_scene == SCENE_PLAYING) && (r_cnt == CNT_TC);
    assign w_rmin   = 8'd3 + {4'd0, w_lfsr[3:0]};
    assign w_sum    = {1'b0, r_score} + 17'(w_nrec);
    assign w_unused = ^{n_col, w_lfsr[7:4]};
    assign w_dead   = r_y[YW-1] || w_hit ||
                      ({1'b0, w_alt} >= {1'b0, n_row});

    always_comb begin
        w_hit  = 1'b0;
        w_rec  = '0;
        w_nrec = '0;
        for (int i = 0; i < N_PIPE; i++) begin
            w_rec[i] = w_tc && (r_pos[i] == 8'd0);
            if (w_rec[i]) w_nrec = w_nrec + NW'(1);
            if ((r_pos[i] <= HIT_POS) &&
                ((w_alt <= r_min[i]) || (w_alt >= r_max[i])))
                w_hit = 1'b1;
        end
    end

    always_comb begin
        w_scene_nxt = r_scene;
        unique case (r_scene)
            SCENE_SPLASH:
                if (inp == KEY_FLAP) w_scene_nxt = SCENE_PLAYING;
            SCENE_PLAYING:
                if (w_dead) w_scene_nxt = SCENE_GAMEOVER;
            SCENE_GAMEOVER:
                if (inp == KEY_RESTART) w_scene_nxt = SCENE_SPLASH;
            default:
                w_scene_nxt = SCENE_SPLASH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_scene <= SCENE_SPLASH;
        else        r_scene <= w_scene_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y        <= '0;
            r_v        <= YW'(VEL0);
            r_a        <= YW'(ACC1);
            r_flapping <= 1'b0;
            r_kpbuf    <= '0;
            r_cnt      <= '0;
            r_score    <= '0;
            for (int i = 0; i < N_PIPE; i++) begin
                r_pos[i] <= 8'((N_PIPE - i) * PIPE_SPACING);
                r_max[i] <= pipe_max0(i);
                r_min[i] <= pipe_max0(i) - 8'(GAP);
            end
        end else begin
            r_kpbuf <= {inp == KEY_FLAP, r_kpbuf[KP_BUFLEN-1:1]};
            case (r_scene)
                SCENE_SPLASH: begin
                    r_y <= {1'b0, n_row >> 1, {FRAC_W{1'b0}}};
                    r_v <= YW'(VEL0);
                    r_a <= YW'(ACC1);
                end
                SCENE_PLAYING: begin
                    r_y        <= r_y + r_v;
                    r_v        <= w_flap ? YW'(VEL0) : r_v + r_a;
                    r_a        <= (r_v > YW'(VEL_BND)) ? YW'(ACC1)
                                                       : YW'(ACC2);
                    r_flapping <= w_flap;
                    r_cnt      <= w_tc ? '0 : r_cnt + CW'(1);
                    r_score    <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
                    for (int i = 0; i < N_PIPE; i++) begin
                        if (w_rec[i]) begin
                            r_pos[i] <= POS_REL;
                            r_min[i] <= w_rmin;
                            r_max[i] <= w_rmin + 8'(GAP);
                        end else if (w_tc) begin
                            r_pos[i] <= r_pos[i] - 8'd1;
                        end
                    end
                end
                SCENE_GAMEOVER: begin
                    if (inp == KEY_RESTART) begin
                        r_v     <= YW'(VEL0);
                        r_cnt   <= '0;
                        r_score <= '0;
                        for (int i = 0; i < N_PIPE; i++) begin
                            r_pos[i] <= 8'((N_PIPE - i) * PIPE_SPACING);
                            r_max[i] <= pipe_max0(i);
                            r_min[i] <= pipe_max0(i) - 8'(GAP);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pipes = '0;
        for (int i = 0; i < N_PIPE; i++) begin
            pipes[24*i+POS_LSB +: 8] = r_pos[i];
            pipes[24*i+MAX_LSB +: 8] = r_max[i];
            pipes[24*i+MIN_LSB +: 8] = r_min[i];
        end
    end

    assign scene = r_scene;
    assign bird  = {w_alt, r_flapping};
    assign score = r_score;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: directed scenarios plus random keys, all
// checked against a frame-level game model kept in the bench.
module tb_flappy_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  inp = 8'd0;
    logic [7:0]  n_row = 8'd40;
    logic [7:0]  n_col = 8'd80;
    logic [1:0]  scene;
    logic [8:0]  bird;
    logic [71:0] pipes;
    logic [15:0] score;

    localparam logic [71:0] PIPES_RST = {
        8'd50, 8'd30, 8'd20,
        8'd100, 8'd25, 8'd15,
        8'd150, 8'd35, 8'd25};

    int n_pass = 0;
    int n_total = 0;

    flappy_game_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .inp   (inp),
        .n_row (n_row),
        .n_col (n_col),
        .scene (scene),
        .bird  (bird),
        .pipes (pipes),
        .score (score)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---- game model: scene, y/v/a in 1/256 units, pipes, score ----
    int m_scene, m_y, m_v, m_a, m_isf, m_cnt;
    int m_score, m_lfsr, m_age, m_rec_lfsr;
    int m_pos[3], m_max[3], m_min[3];

    function automatic int alt_of(input int y);
        if (y < 0) return 0;
        if (y / 256 > 255) return 255;
        return y / 256;
    endfunction

    task automatic m_pipes_init();
        for (int i = 0; i < 3; i++) begin
            m_pos[i] = (3 - i) * 50;
            m_max[i] = 30 - 5 * (i % 2) + ((i == 0) ? 5 : 0);
            m_min[i] = m_max[i] - 10;
        end
    endtask

    task automatic m_reset();
        m_scene = 0; m_y = 0; m_v = 70; m_a = -4; m_isf = 0;
        m_cnt = 0; m_score = 0; m_lfsr = 'hA5; m_age = 1000;
        m_pipes_init();
    endtask

    task automatic m_edge(input int k, input int nr);
        int alt;
        bit flap, dead;
        alt = alt_of(m_y);
        flap = (m_age < 5);
        dead = (m_y < 0) || (alt >= nr);
        for (int i = 0; i < 3; i++)
            if (m_pos[i] <= 6 && (alt <= m_min[i] || alt >= m_max[i]))
                dead = 1;
        case (m_scene)
            0: begin
                m_y = (nr / 2) * 256; m_v = 70; m_a = -4;
                if (k == 32) m_scene = 1;
            end
            1: begin
                int ov;
                ov = m_v;
                m_y = m_y + m_v;
                m_v = flap ? 70 : ov + m_a;
                m_a = (ov > 26) ? -4 : -6;
                m_isf = flap;
                if (m_cnt == 2) begin
                    m_cnt = 0;
                    for (int i = 0; i < 3; i++) begin
                        if (m_pos[i] == 0) begin
                            m_pos[i] = 149;
                            m_min[i] = 3 + (m_lfsr % 16);
                            m_max[i] = m_min[i] + 10;
                            if (m_score < 65535) m_score++;
                            m_rec_lfsr = m_lfsr;
                        end else begin
                            m_pos[i]--;
                        end
                    end
                end else begin
                    m_cnt++;
                end
                if (dead) m_scene = 2;
            end
            default: begin
                if (k == 114) begin
                    m_scene = 0; m_score = 0; m_cnt = 0; m_v = 70;
                    m_pipes_init();
                end
            end
        endcase
        m_age = (k == 32) ? 0 : ((m_age < 1000) ? m_age + 1 : m_age);
        m_lfsr = ((m_lfsr << 1) | ($countones(m_lfsr & 'hB8) % 2)) & 255;
    endtask

    function automatic logic [71:0] exp_pipes();
        logic [71:0] e;
        for (int i = 0; i < 3; i++)
            e[24*i +: 24] = {8'(m_pos[i]), 8'(m_max[i]), 8'(m_min[i])};
        return e;
    endfunction

    function automatic logic [8:0] exp_bird();
        return {8'(alt_of(m_y)), 1'(m_isf)};
    endfunction

    // Flap toward the gap of the nearest pipe, shifted by off rows
    function automatic logic [7:0] ctl(input int off);
        int j, tgt;
        j = 0;
        for (int i = 1; i < 3; i++) if (m_pos[i] < m_pos[j]) j = i;
        tgt = (m_min[j] + m_max[j]) / 2 + off;
        return (alt_of(m_y) < tgt && m_v < 0) ? 8'd32 : 8'd0;
    endfunction

    task automatic step(input logic [7:0] k);
        inp = k;
        @(posedge clk);
        m_edge(int'(k), int'(n_row));
        @(negedge clk);
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        rst_n = 1'b0; n_row = 8'd40; inp = 8'd0;
        m_reset();
        #12;
        n_total++;
        if (scene !== 2'd0) $display("FAIL rst_scene: got %0d want 0", scene);
        else n_pass++;
        n_total++;
        if (score !== 16'd0) $display("FAIL rst_score: got %0d want 0", score);
        else n_pass++;
        n_total++;
        if (bird !== 9'd0) $display("FAIL rst_bird: got %h want 000", bird);
        else n_pass++;
        n_total++;
        if (pipes !== PIPES_RST)
            $display("FAIL rst_pipes: got %h want %h", pipes, PIPES_RST);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step(8'd0);
        n_total++;
        if (bird[8:1] !== 8'd20)
            $display("FAIL splash_alt: got %0d want 20", bird[8:1]);
        else n_pass++;
    endtask

    task automatic test_start();
        step(8'd32);
        n_total++;
        if (scene !== 2'd1) $display("FAIL start_scene: got %0d want 1", scene);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            step(8'd0);
            n_total++;
            if ({scene, bird, pipes, score} !==
                {2'(m_scene), exp_bird(), exp_pipes(), 16'(m_score)})
                $display("FAIL start_state c%0d: got %h %h %h %h want %0d %h %h %0d",
                         c, scene, bird, pipes, score,
                         m_scene, exp_bird(), exp_pipes(), m_score);
            else n_pass++;
        end
        n_total++;
        if (bird[8:1] !== 8'd21)
            $display("FAIL start_alt4: got %0d want 21", bird[8:1]);
        else n_pass++;
    endtask

    task automatic test_ceiling();
        int last_alt;
        last_alt = -1;
        for (int c = 0; c < 300 && m_scene == 1; c++) begin
            step(8'd32);
            n_total++;
            if ({scene, bird, pipes, score} !==
                {2'(m_scene), exp_bird(), exp_pipes(), 16'(m_score)})
                $display("FAIL ceil_state c%0d: got %h %h %h %h want %0d %h %h %0d",
                         c, scene, bird, pipes, score,
                         m_scene, exp_bird(), exp_pipes(), m_score);
            else n_pass++;
            if (scene == 2'd1) last_alt = int'(bird[8:1]);
        end
        n_total++;
        if (scene !== 2'd2) $display("FAIL ceil_dead: got %0d want 2", scene);
        else n_pass++;
        n_total++;
        if (last_alt != 40)
            $display("FAIL ceil_alt: got %0d want 40", last_alt);
        else n_pass++;
        n_total++;
        if (score !== 16'd0) $display("FAIL ceil_score: got %0d want 0", score);
        else n_pass++;
    endtask

    task automatic test_gameover();
        for (int c = 0; c < 3; c++) begin
            step(8'd32);
            n_total++;
            if ({scene, bird, pipes, score} !==
                {2'(m_scene), exp_bird(), exp_pipes(), 16'(m_score)})
                $display("FAIL go_hold c%0d: got %h %h %h %h want %0d %h %h %0d",
                         c, scene, bird, pipes, score,
                         m_scene, exp_bird(), exp_pipes(), m_score);
            else n_pass++;
        end
        step(8'd114);
        n_total++;
        if (scene !== 2'd0) $display("FAIL go_restart: got %0d want 0", scene);
        else n_pass++;
        n_total++;
        if (pipes !== PIPES_RST)
            $display("FAIL go_pipes: got %h want %h", pipes, PIPES_RST);
        else n_pass++;
        n_total++;
        if (score !== 16'd0) $display("FAIL go_score: got %0d want 0", score);
        else n_pass++;
    endtask

    task automatic test_recycle();
        int zero_c, prev_score;
        bit done;
        zero_c = -1; done = 0;
        n_row = 8'd52;
        step(8'd0);
        step(8'd32);
        for (int c = 0; c < 600 && !done; c++) begin
            prev_score = m_score;
            step(ctl(0));
            n_total++;
            if ({scene, bird, pipes, score} !==
                {2'(m_scene), exp_bird(), exp_pipes(), 16'(m_score)})
                $display("FAIL rec_state c%0d: got %h %h %h %h want %0d %h %h %0d",
                         c, scene, bird, pipes, score,
                         m_scene, exp_bird(), exp_pipes(), m_score);
            else n_pass++;
            if (zero_c < 0 && pipes[71:64] == 8'd0) zero_c = c;
            if (m_score != prev_score) begin
                done = 1;
                n_total++;
                if (c - zero_c != 3)
                    $display("FAIL rec_delay: got %0d want 3", c - zero_c);
                else n_pass++;
                n_total++;
                if (pipes[71:64] !== 8'd149)
                    $display("FAIL rec_pos: got %0d want 149", pipes[71:64]);
                else n_pass++;
                n_total++;
                if (pipes[55:48] !== 8'(3 + m_rec_lfsr % 16))
                    $display("FAIL rec_min: got %0d want %0d",
                             pipes[55:48], 3 + m_rec_lfsr % 16);
                else n_pass++;
                n_total++;
                if (pipes[63:56] !== 8'(13 + m_rec_lfsr % 16))
                    $display("FAIL rec_max: got %0d want %0d",
                             pipes[63:56], 13 + m_rec_lfsr % 16);
                else n_pass++;
                n_total++;
                if (score !== 16'd1)
                    $display("FAIL rec_score: got %0d want 1", score);
                else n_pass++;
            end
            if (m_scene != 1) break;
        end
        n_total++;
        if (!done || scene !== 2'd1)
            $display("FAIL rec_reached: got done=%0d scene=%0d want 1/1",
                     done, scene);
        else n_pass++;
    endtask

    task automatic test_collision();
        bit hit_seen;
        hit_seen = 0;
        for (int c = 0; c < 600 && m_scene == 1; c++) begin
            step(ctl(-9));
            n_total++;
            if ({scene, bird, pipes, score} !==
                {2'(m_scene), exp_bird(), exp_pipes(), 16'(m_score)})
                $display("FAIL col_state c%0d: got %h %h %h %h want %0d %h %h %0d",
                         c, scene, bird, pipes, score,
                         m_scene, exp_bird(), exp_pipes(), m_score);
            else n_pass++;
            if (scene == 2'd1) begin
                hit_seen = 0;
                for (int i = 0; i < 3; i++)
                    if (pipes[24*i+16 +: 8] <= 8'd6 &&
                        (bird[8:1] <= pipes[24*i +: 8] ||
                         bird[8:1] >= pipes[24*i+8 +: 8]))
                        hit_seen = 1;
            end
        end
        n_total++;
        if (scene !== 2'd2) $display("FAIL col_dead: got %0d want 2", scene);
        else n_pass++;
        n_total++;
        if (hit_seen !== 1'b1)
            $display("FAIL col_cause: got hit=%0d want 1", hit_seen);
        else n_pass++;
    endtask

    task automatic test_random();
        int r;
        logic [7:0] k;
        for (int c = 0; c < 1500; c++) begin
            if (c % 50 == 0) n_row = 8'($urandom_range(1, 255));
            r = $urandom_range(0, 99);
            if (r < 55)      k = 8'd0;
            else if (r < 85) k = 8'd32;
            else if (r < 90) k = 8'd114;
            else             k = 8'($urandom);
            step(k);
            n_total++;
            if ({scene, bird, pipes, score} !==
                {2'(m_scene), exp_bird(), exp_pipes(), 16'(m_score)})
                $display("FAIL rnd_state c%0d: got %h %h %h %h want %0d %h %h %0d",
                         c, scene, bird, pipes, score,
                         m_scene, exp_bird(), exp_pipes(), m_score);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        n_row = 8'd100;
        for (int c = 0; c < 6 && m_scene != 1; c++)
            step((m_scene == 2) ? 8'd114 : 8'd32);
        for (int c = 0; c < 5; c++) begin
            step(8'd0);
            n_total++;
            if ({scene, bird, pipes, score} !==
                {2'(m_scene), exp_bird(), exp_pipes(), 16'(m_score)})
                $display("FAIL ar_pre c%0d: got %h %h %h %h want %0d %h %h %0d",
                         c, scene, bird, pipes, score,
                         m_scene, exp_bird(), exp_pipes(), m_score);
            else n_pass++;
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        m_reset();
        #1;
        n_total++;
        if (scene !== 2'd0) $display("FAIL ar_scene: got %0d want 0", scene);
        else n_pass++;
        n_total++;
        if (bird !== 9'd0) $display("FAIL ar_bird: got %h want 000", bird);
        else n_pass++;
        n_total++;
        if (pipes !== PIPES_RST)
            $display("FAIL ar_pipes: got %h want %h", pipes, PIPES_RST);
        else n_pass++;
        n_total++;
        if (score !== 16'd0) $display("FAIL ar_score: got %0d want 0", score);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step(8'd0);
        n_total++;
        if ({scene, bird, pipes, score} !==
            {2'(m_scene), exp_bird(), exp_pipes(), 16'(m_score)})
            $display("FAIL ar_post: got %h %h %h %h want %0d %h %h %0d",
                     scene, bird, pipes, score,
                     m_scene, exp_bird(), exp_pipes(), m_score);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_ceiling();
        test_gameover();
        test_recycle();
        test_collision();
        test_gameover();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
